// File: rtl/mipi_delay_calib.sv
// mipi_delay_calib
//   Training controller for one MIPI lane iodelay. On a start pulse it sweeps
//   every tap 0..2^N-1. For each tap it writes the tap, waits for the delay
//   line and deserializer to refill, and checks the incoming bytes against the
//   HS sync pattern. It tracks the longest contiguous passing window (lowest
//   window wins a tie, no wrap from the top tap to tap 0) and finally writes
//   the window centre back to the iodelay.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   in_start      1-cycle start pulse, ignored while busy
//   in_byte       deserialized byte from the lane
//   in_byte_vld   in_byte qualifier
//   out_delay     tap value to the iodelay
//   out_delay_we  1-cycle write strobe to the iodelay
//   out_busy      sweep in progress
//   out_done      calibration finished (level, held until next start)
//   out_fail      no window of at least P_MIN_EYE taps (level)
//   out_eye_lo    first tap of the chosen window
//   out_eye_hi    last tap of the chosen window
//   out_err_cnt   mismatched valid bytes over the sweep (saturating)
//
// Build options
//   MIPI_IODELAY_NBIT     default tap width (5 if not defined)
//   MIPI_CALIB_ERRCNT_EN  when defined, out_err_cnt counts mismatched valid
//                         bytes seen during CHECK; otherwise it is tied to 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for in_start; done/fail/eye/err_cnt held
// S_SET    | present the current tap to the iodelay with a write strobe
// S_SETTLE | let the delay line and byte pipeline refill, inputs ignored
// S_CHECK  | sample valid bytes against P_PATTERN for P_CHECK_CYC cycles
// S_EVAL   | fold the tap result into the run / best window, advance tap
// S_FINAL  | write the window centre (or mid tap on failure), flag done

`ifndef MIPI_IODELAY_NBIT
`define MIPI_IODELAY_NBIT 5
`endif

module mipi_delay_calib #(
  parameter int         P_DELAY_NBIT = `MIPI_IODELAY_NBIT,
  parameter int         P_SETTLE_CYC = 40,
  parameter int         P_CHECK_CYC  = 256,
  parameter logic [7:0] P_PATTERN    = 8'hB8,
  parameter int         P_MIN_EYE    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_start,
  input  logic [7:0]              in_byte,
  input  logic                    in_byte_vld,
  output logic [P_DELAY_NBIT-1:0] out_delay,
  output logic                    out_delay_we,
  output logic                    out_busy,
  output logic                    out_done,
  output logic                    out_fail,
  output logic [P_DELAY_NBIT-1:0] out_eye_lo,
  output logic [P_DELAY_NBIT-1:0] out_eye_hi,
  output logic [15:0]             out_err_cnt
);

  localparam int N      = P_DELAY_NBIT;
  localparam int L      = P_DELAY_NBIT + 1;
  localparam int CNT_MX = (P_SETTLE_CYC > P_CHECK_CYC) ? P_SETTLE_CYC : P_CHECK_CYC;
  localparam int CW     = $clog2(CNT_MX + 1);

  localparam logic [N-1:0]  TAP_MAX    = '1;
  localparam logic [N-1:0]  TAP_MID    = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] SETTLE_LD  = CW'(P_SETTLE_CYC - 1);
  localparam logic [CW-1:0] CHECK_LD   = CW'(P_CHECK_CYC - 1);
  localparam logic [L-1:0]  MIN_EYE    = L'(P_MIN_EYE);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_CHECK, S_EVAL, S_FINAL
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  tap_q, tap_d;
  logic [N-1:0]  delay_q, delay_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [N-1:0]  eye_lo_q, eye_lo_d;
  logic [N-1:0]  eye_hi_q, eye_hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          bad_q, bad_d;
  logic [L-1:0]  run_len_q, run_len_d;
  logic [N-1:0]  run_start_q, run_start_d;
  logic [L-1:0]  best_len_q, best_len_d;
  logic [N-1:0]  best_start_q, best_start_d;
`ifdef MIPI_CALIB_ERRCNT_EN
  logic [15:0]   err_cnt_q, err_cnt_d;
`endif

  // Centre rounds down: start + floor((len-1)/2), computed one bit wider.
  logic [L-1:0]  centre;
  logic [L-1:0]  best_end;
  assign centre   = {1'b0, best_start_q} + ((best_len_q - L'(1)) >> 1);
  assign best_end = {1'b0, best_start_q} + best_len_q - L'(1);

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    delay_d      = delay_q;
    we_d         = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    eye_lo_d     = eye_lo_q;
    eye_hi_d     = eye_hi_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    bad_d        = bad_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
`ifdef MIPI_CALIB_ERRCNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          done_d       = 1'b0;
          fail_d       = 1'b0;
          run_len_d    = '0;
          run_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
          tap_d        = '0;
          busy_d       = 1'b1;
`ifdef MIPI_CALIB_ERRCNT_EN
          err_cnt_d    = '0;
`endif
          state_d      = S_SET;
        end
      end

      S_SET: begin
        delay_d = tap_q;
        we_d    = 1'b1;
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = CHECK_LD;
          seen_d  = 1'b0;
          bad_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_CHECK: begin
        if (in_byte_vld) begin
          seen_d = 1'b1;
          if (in_byte != P_PATTERN) begin
            bad_d = 1'b1;
`ifdef MIPI_CALIB_ERRCNT_EN
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
          end
        end
        if (cnt_q == '0) state_d = S_EVAL;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_EVAL: begin
        if (seen_q && !bad_q) begin
          run_len_d   = run_len_q + L'(1);
          run_start_d = (run_len_q == '0) ? tap_q : run_start_q;
          // Strict compare keeps the earlier (lower-tap) window on a tie.
          if (run_len_d > best_len_q) begin
            best_len_d   = run_len_d;
            best_start_d = run_start_d;
          end
        end else begin
          run_len_d = '0;
        end
        if (tap_q == TAP_MAX) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + N'(1);
          state_d = S_SET;
        end
      end

      S_FINAL: begin
        if (best_len_q >= MIN_EYE) begin
          delay_d  = N'(centre);
          eye_lo_d = best_start_q;
          eye_hi_d = N'(best_end);
          fail_d   = 1'b0;
        end else begin
          delay_d  = TAP_MID;
          eye_lo_d = '0;
          eye_hi_d = '0;
          fail_d   = 1'b1;
        end
        we_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      delay_q      <= TAP_MID;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_lo_q     <= '0;
      eye_hi_q     <= '0;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      bad_q        <= 1'b0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
`ifdef MIPI_CALIB_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      delay_q      <= delay_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_lo_q     <= eye_lo_d;
      eye_hi_q     <= eye_hi_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      bad_q        <= bad_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
`ifdef MIPI_CALIB_ERRCNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign out_delay    = delay_q;
  assign out_delay_we = we_q;
  assign out_busy     = busy_q;
  assign out_done     = done_q;
  assign out_fail     = fail_q;
  assign out_eye_lo   = eye_lo_q;
  assign out_eye_hi   = eye_hi_q;
`ifdef MIPI_CALIB_ERRCNT_EN
  assign out_err_cnt  = err_cnt_q;
`else
  assign out_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_mipi_delay_calib.sv
// tb_mipi_delay_calib
//   Bench for mipi_delay_calib with short settle/check windows. The lane model
//   returns the sync byte when the applied tap is in the pass mask, else junk.
//   Expected sweep results are queued at start and compared at done.

module tb_mipi_delay_calib;

  localparam int N       = 5;
  localparam int S       = 4;
  localparam int C       = 16;
  localparam int NTAP    = 1 << N;
  localparam int T_SWEEP = NTAP * (2 + S + C) + 1;
  localparam int BUDGET  = T_SWEEP + 200;

  logic         clk;
  logic         rst_n;
  logic         in_start;
  logic [7:0]   in_byte;
  logic         in_byte_vld;
  logic [N-1:0] out_delay;
  logic         out_delay_we;
  logic         out_busy;
  logic         out_done;
  logic         out_fail;
  logic [N-1:0] out_eye_lo;
  logic [N-1:0] out_eye_hi;
  logic [15:0]  out_err_cnt;

  mipi_delay_calib #(
    .P_DELAY_NBIT (N),
    .P_SETTLE_CYC (S),
    .P_CHECK_CYC  (C),
    .P_PATTERN    (8'hB8),
    .P_MIN_EYE    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_start     (in_start),
    .in_byte      (in_byte),
    .in_byte_vld  (in_byte_vld),
    .out_delay    (out_delay),
    .out_delay_we (out_delay_we),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_fail     (out_fail),
    .out_eye_lo   (out_eye_lo),
    .out_eye_hi   (out_eye_hi),
    .out_err_cnt  (out_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dly;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic         fl;
    logic [15:0]  err;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pass_mask;
  bit          vld_en;
  bit          inj_settle;
  bit          inj_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Lane model: byte depends on the tap currently applied to the iodelay.
  // Optional junk one cycle after each tap write (inside SETTLE) and one
  // wrong byte mid-CHECK on taps 0..4.
  initial begin : lane
    int since_we;
    since_we    = 1000;
    in_byte     = 8'h00;
    in_byte_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (out_delay_we) since_we = 0;
      else if (since_we < 1000) since_we++;
      in_byte_vld = vld_en;
      in_byte     = pass_mask[out_delay] ? 8'hB8 : 8'h47;
      if (inj_settle && out_busy && since_we == 1) in_byte = 8'h00;
      if (inj_err && out_busy && since_we == S + 2 && out_delay < 5) in_byte = 8'h11;
    end
  end

  function automatic exp_t model(input logic [31:0] m, input logic [15:0] err);
    exp_t e;
    int run, rs, bl, bs;
    run = 0; rs = 0; bl = 0; bs = 0;
    for (int t = 0; t < NTAP; t++) begin
      if (m[t]) begin
        if (run == 0) rs = t;
        run++;
        if (run > bl) begin
          bl = run;
          bs = rs;
        end
      end else begin
        run = 0;
      end
    end
    if (bl >= 4) begin
      e.dly = N'(bs + (bl - 1) / 2);
      e.lo  = N'(bs);
      e.hi  = N'(bs + bl - 1);
      e.fl  = 1'b0;
    end else begin
      e.dly = N'(16);
      e.lo  = '0;
      e.hi  = '0;
      e.fl  = 1'b1;
    end
    e.err = err;
    return e;
  endfunction

  task automatic do_sweep(input string name, input logic [31:0] m, input bit vld,
                          input bit junk, input bit errs, input bit poke7);
    exp_t        e;
    logic [31:0] eff;
    logic [15:0] exp_err;
    int          cycles;
    int          we_cnt;
    bit          poked;

    pass_mask  = m;
    vld_en     = vld;
    inj_settle = junk;
    inj_err    = errs;
    eff        = vld ? m : 32'h0;
    if (errs) eff = eff & ~32'h1F;
`ifdef MIPI_CALIB_ERRCNT_EN
    exp_err = errs ? 16'd5 : 16'd0;
`else
    exp_err = 16'd0;
`endif
    exp_q.push_back(model(eff, exp_err));

    @(negedge clk) in_start = 1'b1;
    @(negedge clk) in_start = 1'b0;
    chk({name, "_busy"}, {31'b0, out_busy}, 32'd1);

    cycles = 0;
    we_cnt = 0;
    poked  = 1'b0;
    while (!out_done && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      if (out_delay_we) we_cnt++;
      if (poke7 && !poked && out_busy && out_delay == 5'd7) begin
        poked    = 1'b1;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        cycles++;
        if (out_delay_we) we_cnt++;
      end
    end

    chk({name, "_done"}, {31'b0, out_done}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_latency"}, cycles,                 T_SWEEP);
      chk({name, "_we_cnt"},  we_cnt,                 NTAP + 1);
      chk({name, "_delay"},   {27'b0, out_delay},     {27'b0, e.dly});
      chk({name, "_eye_lo"},  {27'b0, out_eye_lo},    {27'b0, e.lo});
      chk({name, "_eye_hi"},  {27'b0, out_eye_hi},    {27'b0, e.hi});
      chk({name, "_fail"},    {31'b0, out_fail},      {31'b0, e.fl});
      chk({name, "_err_cnt"}, {16'b0, out_err_cnt},   {16'b0, e.err});
      chk({name, "_idle"},    {31'b0, out_busy},      32'd0);
    end
    // Flags must hold while idle.
    repeat (5) @(negedge clk);
    chk({name, "_done_hold"}, {31'b0, out_done},     32'd1);
    chk({name, "_we_quiet"},  {31'b0, out_delay_we}, 32'd0);
  endtask

  task automatic reset_mid_sweep();
    int cycles;
    pass_mask  = 32'hFFFF_FFFF;
    vld_en     = 1'b1;
    inj_settle = 1'b0;
    inj_err    = 1'b0;
    @(negedge clk) in_start = 1'b1;
    @(negedge clk) in_start = 1'b0;
    cycles = 0;
    while (!(out_busy && out_delay == 5'd12) && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    chk("rst_reached_tap12", {27'b0, out_delay}, 32'd12);
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  {31'b0, out_busy},     32'd0);
    chk("rst_delay", {27'b0, out_delay},    32'd16);
    chk("rst_we",    {31'b0, out_delay_we}, 32'd0);
    chk("rst_done",  {31'b0, out_done},     32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stay_idle", {31'b0, out_busy}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_start   = 1'b0;
    pass_mask  = 32'h0;
    vld_en     = 1'b0;
    inj_settle = 1'b0;
    inj_err    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_delay",  {27'b0, out_delay},   32'd16);
    chk("reset_we",     {31'b0, out_delay_we},32'd0);
    chk("reset_busy",   {31'b0, out_busy},    32'd0);
    chk("reset_done",   {31'b0, out_done},    32'd0);
    chk("reset_fail",   {31'b0, out_fail},    32'd0);
    chk("reset_eye_lo", {27'b0, out_eye_lo},  32'd0);
    chk("reset_eye_hi", {27'b0, out_eye_hi},  32'd0);
    chk("reset_err",    {16'b0, out_err_cnt}, 32'd0);

    do_sweep("all_pass",   32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_sweep("win10_20",   32'h001F_FC00, 1'b1, 1'b0, 1'b0, 1'b1);
    do_sweep("tie",        32'h00F0_0078, 1'b1, 1'b0, 1'b0, 1'b0);
    do_sweep("short_eye",  32'h0000_0700, 1'b1, 1'b0, 1'b0, 1'b0);
    do_sweep("no_vld",     32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_mid_sweep();
    do_sweep("after_rst",  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_sweep("err_inject", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
